seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Multiplexed N-digit BCD-to-7-segment display driver. Generalises the single-digit, fixed-range encoder to a parametrised digit count, a configurable valid range and a selectable segment polarity.
- Time-multiplexes one shared segment bus across DIGITS common-anode/cathode digits.
- Inserts anti-ghosting dead time between digits and uses a tear-free load handshake that commits new values only at frame boundaries.
- Sits between the game/counter logic and the board display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- SCAN_DIV, 1000, clock cycles each digit slot lasts (>= GHOST+1).
- GHOST, 16, cycles at the start of each slot with all digit enables inactive.
- MAX_DIGIT, 9, largest code shown as a numeral; codes above it show a dash.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when 0; 0 = lit when 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle request to capture bcd_in
- bcd_in  in  4*DIGITS  packed BCD; digit k = bcd_in[4k+3:4k], digit 0 rightmost
- ready  out  1  high when no captured value is waiting to commit
- seg  out  7  {A,B,C,D,E,F,G}, A = seg[6], polarity per SEG_ACTIVE_LOW
- an  out  DIGITS  digit enables, active-low, one-hot-low when active
- digit_idx  out  clog2(DIGITS) (min 1)  index of the digit currently in its slot
- frame_done  out  1  one-cycle pulse when digit_idx wraps DIGITS-1 -> 0

Behaviour:
- Clocking: single clock clk. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on rst_n low, independent of clk.
- Reset values:
  - seg = all segments off (7'b1111111 if SEG_ACTIVE_LOW, else 0).
  - an = all 1, digit_idx = 0, frame_done = 0, ready = 1.
  - Prescaler = 0, display register = 0, shadow register = 0.
- Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and digit_idx advances, wrapping DIGITS-1 -> 0.
- frame_done is registered high for exactly the cycle after the wrap to 0.
- an and seg are registered outputs, one cycle latency from the prescaler/digit_idx state:
  - Prescaler < GHOST: an = all 1 and seg = all off (dead time).
  - Otherwise: an[digit_idx] = 0, other bits 1, and seg = encode(display digit digit_idx).
- Encoding, active-high view, then inverted if SEG_ACTIVE_LOW:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Any code > MAX_DIGIT, including 10..15: dash = 0000001 (G only).
- Load handshake:
  - load = 1 copies bcd_in into shadow and sets pending (ready = 0 next cycle).
  - A second load before commit overwrites shadow; the last value wins.
  - load is honoured regardless of ready; ready is advisory.
- Commit: in the cycle where digit_idx wraps DIGITS-1 -> 0, if pending, display <= shadow and pending clears (ready = 1 next cycle).
- Load coincident with the commit cycle: display <= bcd_in directly, pending = 0, shadow <= bcd_in.
- The display register never changes mid-frame, so there is no tearing.
- DIGITS = 1: digit_idx stays 0, and every prescaler wrap is a frame wrap and a commit point.
- Reset mid-frame or mid-pending: any pending value is discarded and the display shows 0 on all digits after the first GHOST cycles.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit whose display code is 0 and whose more-significant digits (indices > k) are all 0 is blanked: seg all off, an still driven.
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - Blanking is evaluated on the display register, not on shadow.
- Undefined: all digits always displayed, including leading zeros.

Test Plan:
- Reset: hold rst_n = 0 mid-slot with clk running, DIGITS=4, SCAN_DIV=4, GHOST=1, SEG_ACTIVE_LOW=1 -> seg = 1111111, an = 1111, ready = 1, frame_done = 0, asynchronously. After release, the first active slot shows an = 1110, seg = 0000001.
- Scan order: display = 0x2108 -> an sequence 1110/1101/1011/0111.
  - seg per slot: 0000000 (8), 0000001 (0), 1001111 (1), 0010010 (2).
  - Each slot is preceded by 1 cycle of an = 1111.
  - frame_done pulses every 16 cycles.
- Tear-free load: pulse load with 0x0012 mid-frame -> ready = 0 next cycle. The current frame still shows the old value. Commit happens at the wrap, ready = 1 the cycle after, and the next frame shows 0012.
- Overwrite plus coincident load: load 0x1111, then load 0x2222 in the commit cycle -> display = 2222 from the next frame, ready stays 1 after commit.
- Invalid codes with MAX_DIGIT = 2: digits 3, 9 and 15 -> seg = 1111110 (dash). Digit 2 -> 0010010.
- With SEG7_LEADING_ZERO_BLANK_EN: display 0x0010 -> digits 3 and 2 have seg = 1111111, digit 1 shows 1001111, digit 0 shows 0000001. Display 0x0000 shows only digit 0 as "0".

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit BCD-to-7-segment scan driver
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int GHOST          = 16,
  parameter int MAX_DIGIT      = 9,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_ONE   = 1;
  localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(SCAN_DIV - 1);
  localparam logic [PSC_W-1:0]  PSC_DEAD = PSC_W'(GHOST);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PSC_W-1:0]    psc;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] display;
  logic                pending;
  logic                slot_wrap;
  logic                frame_wrap;
  logic [3:0]          cur_code;
  logic                blank;

  // Active-high pattern for a code; codes past MAX_DIGIT (or past 9) show a dash.
  function automatic logic [6:0] encode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = 7'b0000001;
    endcase
    if (32'(code) > MAX_DIGIT) pat = 7'b0000001;
    return (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
  endfunction

  assign slot_wrap  = (psc == PSC_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == IDX_LAST);
  assign cur_code   = display[{digit_idx, 2'b00} +: 4];
  assign ready      = ~pending;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank a non-rightmost digit when it and every more-significant digit is zero.
  always_comb begin
    blank = 1'b0;
    if (digit_idx != '0) begin
      blank = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (k >= int'(digit_idx) && display[4*k +: 4] != 4'd0) blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Slot timebase: prescaler, digit index and the frame-wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc        <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (slot_wrap) begin
        psc       <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
    end
  end

  // Load handshake: shadow collects the latest value, display only moves at a frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (frame_wrap) begin
      if (load) begin
        shadow  <= bcd_in;
        display <= bcd_in;
      end else if (pending) begin
        display <= shadow;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= bcd_in;
      pending <= 1'b1;
    end
  end

  // Registered pin drive: dead time at the start of each slot, then the selected digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else if (psc < PSC_DEAD) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(AN_ONE << digit_idx);
      seg <= blank ? SEG_OFF : encode(cur_code);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int G     = 1;
  localparam int FRAME = D * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        ready0, ready1, fd0, fd1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic [1:0]  idx0, idx1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GHOST(G), .MAX_DIGIT(9), .SEG_ACTIVE_LOW(1)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .ready(ready0),
    .seg(seg0), .an(an0), .digit_idx(idx0), .frame_done(fd0));

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .GHOST(G), .MAX_DIGIT(2), .SEG_ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .ready(ready1),
    .seg(seg1), .an(an1), .digit_idx(idx1), .frame_done(fd1));

  typedef struct {
    logic [3:0] an;
    logic [6:0] sa;
    logic [6:0] sb;
    logic [1:0] idx;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  // Reference state: edges since reset, the value on the display and the latest pending load.
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_latest;
  bit          m_waiting;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Segments for one digit from the numeral table, as the pins should see them.
  function automatic logic [6:0] glyph(input int code, input int maxd, input bit low, input bit blank);
    logic [6:0] tbl [10];
    logic [6:0] p;
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    if (blank)                      p = 7'b0000000;
    else if (code > maxd || code > 9) p = 7'b0000001;
    else                            p = tbl[code];
    return low ? ~p : p;
  endfunction

  // Model: what the pins show after each clock edge, derived from the edge count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_disp = '0; m_latest = '0; m_waiting = 0;
      q.delete();
    end else begin
      exp_t e;
      int   slot_pos, digit, code;
      bit   fw, blank;
      slot_pos = k % SD;
      digit    = (k / SD) % D;
      fw       = (k % FRAME) == FRAME - 1;
      code     = (m_disp >> (4 * digit)) & 16'hF;
      blank    = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      blank    = (digit != 0) && ((m_disp >> (4 * digit)) == 0);
`endif
      if (slot_pos < G) begin
        e.an = 4'hF; e.sa = 7'h7F; e.sb = 7'h00;
      end else begin
        e.an = 4'hF & ~(4'h1 << digit);
        e.sa = glyph(code, 9, 1'b1, blank);
        e.sb = glyph(code, 2, 1'b0, blank);
      end
      e.idx = 2'(((k + 1) / SD) % D);
      e.fd  = fw;
      if (load) m_latest = bcd_in;
      if (fw) begin
        if (load || m_waiting) m_disp = m_latest;
        m_waiting = 0;
      end else if (load) begin
        m_waiting = 1;
      end
      e.rdy = !m_waiting;
      q.push_back(e);
      k++;
    end
  end

  // Monitor: compare every presented output against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("an",         32'(an0),    32'(e.an));
      chk("seg",        32'(seg0),   32'(e.sa));
      chk("digit_idx",  32'(idx0),   32'(e.idx));
      chk("frame_done", 32'(fd0),    32'(e.fd));
      chk("ready",      32'(ready0), 32'(e.rdy));
      chk("an_b",       32'(an1),    32'(e.an));
      chk("seg_b",      32'(seg1),   32'(e.sb));
      chk("ready_b",    32'(ready1), 32'(e.rdy));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Advance until the next edge has the wanted position within the frame.
  task automatic to_phase(input int p);
    for (int i = 0; i < 2 * FRAME && (k % FRAME) != p; i++) begin
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  // Load presented on the edge with frame position p.
  task automatic load_at(input int p, input logic [15:0] v);
    @(negedge clk);
    load = 1'b0;
    to_phase(p);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_seg",   32'(seg0),   32'h7F);
    chk("rst_seg_b", 32'(seg1),   32'h00);
    chk("rst_an",    32'(an0),    32'hF);
    chk("rst_idx",   32'(idx0),   32'h0);
    chk("rst_fd",    32'(fd0),    32'h0);
    chk("rst_ready", 32'(ready0), 32'h1);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    #23;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);

    do_load(16'h2108);
    idle(40);

    load_at(5, 16'h0012);
    idle(40);

    load_at(3, 16'h1111);
    load_at(FRAME - 1, 16'h2222);
    idle(40);

    do_load(16'h39F2);
    idle(40);
    do_load(16'h0010);
    idle(40);
    do_load(16'h0000);
    idle(40);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      load   = ($urandom_range(0, 6) == 0);
      bcd_in = 16'($urandom >> (4 * $urandom_range(0, 4)));
    end
    idle(20);

    do_load(16'h8765);
    idle(36);
    load_at(6, 16'h5555);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    idle(3);
    rst_n = 1'b1;
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
